// File: rtl/deinterleaver_qpsk_wifi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// deinterleaver_qpsk_wifi
// Block deinterleaver placed after the 802.11a QPSK demapper. Hard-decision
// dibits are written row-wise into ROWS x COLS bit blocks held in two
// ping-pong banks. Each full block is read back column-wise as dibits in
// the order the rate-1/2 Viterbi decoder consumes. There is no backpressure
// on either side; both sides run at up to one dibit per cycle.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   flush        (only with DEINTERLEAVER_FLUSH_EN) discard partial write bank
//   valid_in     input dibit strobe
//   data_in[1:0] [1] = bit j, [0] = bit j+1
//   valid_out    output dibit strobe
//   data_out     [1] = deinterleaved bit k, [0] = bit k+1
//   block_start  high with the first output dibit of each block
//   overflow     sticky: an input dibit was dropped (both banks busy)
//
// Optional feature macro: DEINTERLEAVER_FLUSH_EN adds the flush input.
// -----------------------------------------------------------------------------
module deinterleaver_qpsk_wifi #(
    parameter int ROWS = 16,
    parameter int COLS = 6
) (
    input  logic       clk,
    input  logic       reset,
`ifdef DEINTERLEAVER_FLUSH_EN
    input  logic       flush,
`endif
    input  logic       valid_in,
    input  logic [1:0] data_in,
    output logic       valid_out,
    output logic [1:0] data_out,
    output logic       block_start,
    output logic       overflow
);

    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS + 1);

    localparam logic [AW-1:0] W_LAST   = AW'(N - 2);
    localparam logic [AW-1:0] A_COLS   = AW'(COLS);
    localparam logic [AW-1:0] A_STEP   = AW'(2 * COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 2);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    logic [N-1:0] r_bank [2];
    bank_state_t  r_bst [2];
    bank_state_t  w_bst_nxt [2];

    logic          r_wbank;
    logic [AW-1:0] r_widx;
    logic          r_rbank;
    rd_state_t     r_rd_state, w_rd_state_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;

    logic       r_valid_out, w_valid_out_nxt;
    logic [1:0] r_data_out, w_data_out_nxt;
    logic       r_block_start, w_block_start_nxt;
    logic       r_overflow;

    logic w_flush;
    logic w_start;
    logic w_final;
    logic w_wr_open;
    logic w_wr_en;
    logic w_drop;

`ifdef DEINTERLEAVER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // The reader issues the first dibit of a block in the same cycle it claims
    // the bank, so a block that became FULL at edge E is visible after E+1.
    assign w_start = (r_rd_state == RD_IDLE) && (r_bst[r_rbank] == BANK_FULL);
    assign w_final = (r_rd_state == RD_READ) && (r_row == ROW_LAST) && (r_col == COL_LAST);

    // A bank being released by the reader on this edge may be written now.
    assign w_wr_open = (r_bst[r_wbank] == BANK_EMPTY) || (r_bst[r_wbank] == BANK_FILLING) ||
                       (w_final && (r_rbank == r_wbank));
    assign w_wr_en   = valid_in && !w_flush && w_wr_open;
    assign w_drop    = valid_in && !w_flush && !w_wr_open;

    // Next bank state: reader release/claim first, then flush, then writer.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bst_nxt[b] = r_bst[b];
            if (w_final && (r_rbank == 1'(b))) begin
                w_bst_nxt[b] = BANK_EMPTY;
            end else if (w_start && (r_rbank == 1'(b))) begin
                w_bst_nxt[b] = BANK_DRAINING;
            end else begin
                w_bst_nxt[b] = r_bst[b];
            end
            if (w_flush && (r_wbank == 1'(b)) && (r_bst[b] == BANK_FILLING)) begin
                w_bst_nxt[b] = BANK_EMPTY;
            end else if (w_wr_en && (r_wbank == 1'(b))) begin
                w_bst_nxt[b] = (r_widx == W_LAST) ? BANK_FULL : BANK_FILLING;
            end else begin
                w_bst_nxt[b] = w_bst_nxt[b];
            end
        end
    end

    // Reader next-state and output data; r_row/r_col/r_addr name the dibit
    // emitted at the next edge while reading. r_addr tracks row*COLS+col.
    always_comb begin
        w_rd_state_nxt    = r_rd_state;
        w_row_nxt         = r_row;
        w_col_nxt         = r_col;
        w_addr_nxt        = r_addr;
        w_valid_out_nxt   = 1'b0;
        w_data_out_nxt    = 2'b00;
        w_block_start_nxt = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_start) begin
                    w_rd_state_nxt    = RD_READ;
                    w_valid_out_nxt   = 1'b1;
                    w_block_start_nxt = 1'b1;
                    w_data_out_nxt    = {r_bank[r_rbank][AW'(0)], r_bank[r_rbank][A_COLS]};
                    w_row_nxt         = RW'(2);
                    w_col_nxt         = '0;
                    w_addr_nxt        = A_STEP;
                end else begin
                    w_rd_state_nxt    = RD_IDLE;
                end
            end
            RD_READ: begin
                w_valid_out_nxt = 1'b1;
                w_data_out_nxt  = {r_bank[r_rbank][r_addr], r_bank[r_rbank][r_addr + A_COLS]};
                if (w_final) begin
                    // Back to IDLE; if the other bank is already FULL the
                    // next edge starts it, so there is no output bubble.
                    w_rd_state_nxt = RD_IDLE;
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                    w_addr_nxt     = '0;
                end else if (r_row == ROW_LAST) begin
                    w_row_nxt  = '0;
                    w_col_nxt  = r_col + CW'(1);
                    w_addr_nxt = AW'(r_col) + AW'(1);
                end else begin
                    w_row_nxt  = r_row + RW'(2);
                    w_addr_nxt = r_addr + A_STEP;
                end
            end
            default: begin
                w_rd_state_nxt = RD_IDLE;
            end
        endcase
    end

    // State register: banks, writer pointer, reader FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank[0]     <= '0;
            r_bank[1]     <= '0;
            r_bst[0]      <= BANK_EMPTY;
            r_bst[1]      <= BANK_EMPTY;
            r_wbank       <= 1'b0;
            r_widx        <= '0;
            r_rbank       <= 1'b0;
            r_rd_state    <= RD_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_addr        <= '0;
            r_valid_out   <= 1'b0;
            r_data_out    <= 2'b00;
            r_block_start <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_bst[0] <= w_bst_nxt[0];
            r_bst[1] <= w_bst_nxt[1];
            if (w_flush) begin
                r_widx <= '0;
            end else if (w_wr_en) begin
                r_bank[r_wbank][r_widx]          <= data_in[1];
                r_bank[r_wbank][r_widx + AW'(1)] <= data_in[0];
                if (r_widx == W_LAST) begin
                    r_widx  <= '0;
                    r_wbank <= ~r_wbank;
                end else begin
                    r_widx  <= r_widx + AW'(2);
                end
            end
            if (w_final) begin
                r_rbank <= ~r_rbank;
            end
            r_rd_state    <= w_rd_state_nxt;
            r_row         <= w_row_nxt;
            r_col         <= w_col_nxt;
            r_addr        <= w_addr_nxt;
            r_valid_out   <= w_valid_out_nxt;
            r_data_out    <= w_data_out_nxt;
            r_block_start <= w_block_start_nxt;
            r_overflow    <= r_overflow | w_drop;
        end
    end

    assign valid_out   = r_valid_out;
    assign data_out    = r_data_out;
    assign block_start = r_block_start;
    assign overflow    = r_overflow;

endmodule
